// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a small byte FIFO: 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a byte pushed into an empty FIFO while idle is popped one HCLK later; tx drops on that edge.
// Backpressure: wr_ready is a registered "FIFO not full"; queued frames go out back-to-back with no idle gap.
`timescale 1ns/1ps

module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] baud_div,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        tx,
    output logic        busy,
    output logic [4:0]  fifo_level
);

    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [4:0]    level_q;
    logic [4:0]    level_d;
    logic          wr_ready_q;
    logic          push;
    logic          pop;

    // Transmit engine
    state_t        state_q;
    state_t        state_d;
    logic          tx_q;
    logic          tx_d;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [15:0]   baud_cnt_q;
    logic [15:0]   baud_cnt_d;
    logic [15:0]   div_q;
    logic [15:0]   div_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic [15:0]   eff_div;
    logic          bit_end;

    assign push       = wr_valid && wr_ready_q;
    assign eff_div    = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign bit_end    = (baud_cnt_q == 16'd0);

    assign wr_ready   = wr_ready_q;
    assign tx         = tx_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE) || (level_q != 5'd0);

    // Next occupancy: simultaneous push and pop cancel out
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 5'd1;
        end else if (!push && pop) begin
            level_d = level_q - 5'd1;
        end
    end

    // FIFO payload write; contents need no reset because the level gates every read
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, level and registered ready (computed from the next level so a full FIFO never over-admits)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q    <= level_d;
            wr_ready_q <= (level_d != DEPTH_L);
        end
    end

    // Next-state, next-tx and counter logic; a pop latches the head byte and the divisor for the whole frame
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        data_d     = data_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (level_q != 5'd0) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    bit_idx_d  = 3'd0;
                    tx_d       = data_q[0];
                    baud_cnt_d = div_q - 16'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    baud_cnt_d = div_q - 16'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (level_q != 5'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start shared by IDLE and the back-to-back STOP exit
        if (pop) begin
            state_d    = START;
            tx_d       = 1'b0;
            data_d     = mem[rd_ptr_q];
            div_d      = eff_div;
            baud_cnt_d = eff_div - 16'd1;
            bit_idx_d  = 3'd0;
        end
    end

    // Transmit engine state; tx comes straight from this flop
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            div_q      <= 16'd1;
            data_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, single frames, FIFO fill, divisor edge cases, mid-frame reset.
// Latency: expected line values are checked every HCLK, sampled on the falling edge.
// Backpressure: producer side honours wr_ready as sampled before each rising edge.
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic [15:0] baud_div;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_level;

    int tests;
    int fails;

    uart_tx_ctrl #(.FIFO_DEPTH(4)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .baud_div   (baud_div),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Expected line level k cycles after frame start for byte d at divisor div
    function automatic logic exp_bit(input logic [7:0] d, input int div, input int k);
        int dd;
        int b;
        dd = (div == 0) ? 1 : div;
        b  = k / dd;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        #2 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (tx !== 1'b1)         begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        tests++; if (wr_ready !== 1'b1)   begin fails++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    endtask

    // Releases reset and pushes 0x55 on the very first edge afterwards
    task automatic test_single_frame();
        logic [7:0] d;
        d = 8'h55;
        baud_div = 16'd10;
        wr_data  = d;
        wr_valid = 1'b1;
        HRESETn  = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_valid = 1'b0;
        tests++; if (fifo_level !== 5'd1) begin fails++; $display("FAIL first_push_level got %0d want 1", fifo_level); end
        tests++; if (tx !== 1'b1)         begin fails++; $display("FAIL pre_pop_tx got %b want 1", tx); end
        for (int k = 0; k < FL * 10; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            if (k == 0) begin
                tests++; if (busy !== 1'b1)       begin fails++; $display("FAIL single_busy got %b want 1", busy); end
                tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL single_pop_level got %0d want 0", fifo_level); end
            end
            tests++;
            if (tx !== exp_bit(d, 10, k)) begin
                fails++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_bit(d, 10, k));
            end
        end
        @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", busy); end
        tests++; if (tx !== 1'b1)   begin fails++; $display("FAIL single_idle_tx got %b want 1", tx); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [6];
        int   acc;
        int   last;
        logic rdy_s;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        baud_div = 16'd10;
        acc  = 0;
        last = 20;
        wr_data  = bytes[0];
        wr_valid = 1'b1;
        rdy_s    = wr_ready;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge HCLK);
            if (rdy_s) acc++;
            @(negedge HCLK);
            if (cyc >= 1) begin
                tests++;
                if (tx !== exp_bit(bytes[0], 10, cyc - 1)) begin
                    fails++; $display("FAIL fill_tx k=%0d got %b want %b", cyc - 1, tx, exp_bit(bytes[0], 10, cyc - 1));
                end
            end
            rdy_s = wr_ready;
            if (!wr_ready) begin
                last = cyc;
                break;
            end
            if (acc < 6) wr_data = bytes[acc];
        end
        wr_valid = 1'b0;
        tests++; if (acc !== 5)            begin fails++; $display("FAIL fill_accepted got %0d want 5", acc); end
        tests++; if (fifo_level !== 5'd4)  begin fails++; $display("FAIL fill_level got %0d want 4", fifo_level); end
        for (int k = last; k < 5 * FL * 10; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            if (k == FL * 10 - 1) begin
                tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL full_ready_held got %b want 0", wr_ready); end
            end
            if (k == FL * 10) begin
                tests++; if (wr_ready !== 1'b1)   begin fails++; $display("FAIL full_ready_release got %b want 1", wr_ready); end
                tests++; if (fifo_level !== 5'd3) begin fails++; $display("FAIL full_level_after_pop got %0d want 3", fifo_level); end
            end
            tests++;
            if (tx !== exp_bit(bytes[k / (FL * 10)], 10, k % (FL * 10))) begin
                fails++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx, exp_bit(bytes[k / (FL * 10)], 10, k % (FL * 10)));
            end
        end
        @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_div_zero();
        logic [7:0] d;
        d = 8'hA3;
        baud_div = 16'd0;
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            tests++;
            if (tx !== exp_bit(d, 1, k)) begin
                fails++; $display("FAIL div0_tx k=%0d got %b want %b", k, tx, exp_bit(d, 1, k));
            end
        end
        @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div0_idle_busy got %b want 0", busy); end
        baud_div = 16'd10;
    endtask

    task automatic test_baud_change();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h3C;
        b = 8'hC5;
        baud_div = 16'd10;
        wr_data  = a;
        wr_valid = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_data = b;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_valid = 1'b0;
        for (int k = 0; k < FL * 10; k++) begin
            if (k > 0) begin
                @(posedge HCLK);
                @(negedge HCLK);
            end
            tests++;
            if (tx !== exp_bit(a, 10, k)) begin
                fails++; $display("FAIL baud_f1_tx k=%0d got %b want %b", k, tx, exp_bit(a, 10, k));
            end
            if (k == 5) baud_div = 16'd20;
        end
        for (int k = 0; k < FL * 20; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            tests++;
            if (tx !== exp_bit(b, 20, k)) begin
                fails++; $display("FAIL baud_f2_tx k=%0d got %b want %b", k, tx, exp_bit(b, 20, k));
            end
        end
        @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL baud_idle_busy got %b want 0", busy); end
        baud_div = 16'd10;
    endtask

    task automatic test_reset_mid_frame();
        baud_div = 16'd10;
        wr_data  = 8'h11;
        wr_valid = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_data = 8'h22;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_data = 8'h33;
        @(posedge HCLK);
        @(negedge HCLK);
        wr_valid = 1'b0;
        repeat (30) begin
            @(posedge HCLK);
            @(negedge HCLK);
        end
        // 31 cycles into frame 0x11: data bit 2, which is 0
        tests++; if (tx !== 1'b0)         begin fails++; $display("FAIL mid_pre_tx got %b want 0", tx); end
        tests++; if (fifo_level !== 5'd2) begin fails++; $display("FAIL mid_pre_level got %0d want 2", fifo_level); end
        #1 HRESETn = 1'b0;
        #1;
        tests++; if (tx !== 1'b1)         begin fails++; $display("FAIL mid_rst_tx got %b want 1", tx); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        tests++; if (wr_ready !== 1'b1)   begin fails++; $display("FAIL mid_rst_ready got %b want 1", wr_ready); end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            tests++;
            if (tx !== 1'b1) begin fails++; $display("FAIL post_rst_tx k=%0d got %b want 1", k, tx); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy got %b want 0", busy); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       par  [2];
        vals = '{8'h07, 8'h03};
        par  = '{1'b1, 1'b0};
        baud_div = 16'd10;
        for (int i = 0; i < 2; i++) begin
            wr_data  = vals[i];
            wr_valid = 1'b1;
            @(posedge HCLK);
            @(negedge HCLK);
            wr_valid = 1'b0;
            for (int k = 0; k < 110; k++) begin
                @(posedge HCLK);
                @(negedge HCLK);
                if (k >= 90 && k < 100) begin
                    tests++;
                    if (tx !== par[i]) begin fails++; $display("FAIL parity_bit val=%h k=%0d got %b want %b", vals[i], k, tx, par[i]); end
                end
            end
            @(posedge HCLK);
            @(negedge HCLK);
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL parity_idle_busy got %b want 0", busy); end
        end
    endtask
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        HRESETn  = 1'b1;
        baud_div = 16'd10;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_div_zero();
        test_baud_change();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
